// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network datapath blocks.
// Holds the scheduler state encoding and the default sizing.
package snn_pkg;

    localparam int DEF_N_SRC  = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 10;
    localparam int SRC_IDX_W  = $clog2(DEF_N_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        TICK  = 2'd3
    } state_t;

endpackage

// File: rtl/spike_event_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: masked first-set search starting at i_rr_ptr
// and wrapping from N_SRC-1 back to 0.
module rr_arbiter #(
    parameter int N_SRC = 16,
    parameter int IDX_W = 4
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [N_SRC-1:0] i_mask,
    input  logic [IDX_W-1:0] i_rr_ptr,
    output logic [N_SRC-1:0] o_grant_oh,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [N_SRC-1:0] w_avail;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    assign w_avail = i_req & ~i_mask;
    assign o_any   = |w_avail;

    always_comb begin
        // NOTE: every output gets a default before the search so no path infers a latch.
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_idx       = '0;
        w_found     = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            w_idx = IDX_W'((int'(i_rr_ptr) + i) % N_SRC);
            if (!w_found && w_avail[w_idx]) begin
                w_found            = 1'b1;
                o_grant_idx        = w_idx;
                o_grant_oh[w_idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spike_event_scheduler.sv
// Serialises spike events from N_SRC requesters onto one shared weight/neuron port
// and frames each timestep with a drain followed by a one-cycle timer_en tick.
module spike_event_scheduler
    import snn_pkg::*;
#(
    parameter int N_SRC  = DEF_N_SRC,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              i_step_start,
    input  logic                              i_step_close,
    input  logic [N_SRC-1:0]                  i_req,
    input  logic [N_SRC*ADDR_W-1:0]           i_src_addr,
    output logic [N_SRC-1:0]                  o_ack,
    output logic                              o_ev_valid,
    input  logic                              i_ev_ready,
    output logic [$clog2(N_SRC)+ADDR_W-1:0]   o_ev_addr,
    output logic                              o_timer_en,
    output logic                              o_busy,
    output logic [CNT_W-1:0]                  o_ev_count,
    output logic                              o_ev_ovf
);

    localparam int IDX_W = $clog2(N_SRC);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IDX_W-1:0]          r_rr_ptr;
    logic                      r_close_pending;
    logic [N_SRC-1:0]          r_ack;
    logic                      r_ev_valid;
    logic [IDX_W+ADDR_W-1:0]   r_ev_addr;
    logic [CNT_W-1:0]          r_ev_count;
    logic                      r_ev_ovf;

    logic [N_SRC-1:0]          w_grant_oh;
    logic [IDX_W-1:0]          w_grant_idx;
    logic                      w_any;
    logic                      w_out_free;
    logic                      w_grant;
    logic [ADDR_W-1:0]         w_sel_addr;
    logic [IDX_W-1:0]          w_ptr_next;

    // The ack register doubles as the mask: a requester drops req one cycle after its ack.
    rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_arb (
        .i_req       (i_req),
        .i_mask      (r_ack),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant_oh  (w_grant_oh),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    assign w_out_free = !r_ev_valid || i_ev_ready;
    assign w_grant    = (r_state == RUN) && w_out_free && w_any;
    assign w_sel_addr = i_src_addr[int'(w_grant_idx)*ADDR_W +: ADDR_W];
    assign w_ptr_next = (w_grant_idx == IDX_W'(N_SRC-1)) ? '0 : w_grant_idx + IDX_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_step_start) w_state_next = RUN;
            RUN:     if (r_close_pending && !w_any) w_state_next = FLUSH;
            FLUSH: begin
                if (w_any)            w_state_next = RUN;
                else if (!r_ev_valid) w_state_next = TICK;
            end
            TICK:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            r_state         <= IDLE;
            r_rr_ptr        <= '0;
            r_close_pending <= 1'b0;
            r_ack           <= '0;
            r_ev_valid      <= 1'b0;
            r_ev_addr       <= '0;
            r_ev_count      <= '0;
            r_ev_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_grant ? w_grant_oh : '0;

            if (w_grant) begin
                r_ev_valid <= 1'b1;
                r_ev_addr  <= {w_grant_idx, w_sel_addr};
                r_rr_ptr   <= w_ptr_next;
            end else if (r_ev_valid && i_ev_ready) begin
                r_ev_valid <= 1'b0;
            end

            if (r_state == IDLE && i_step_start) begin
                r_ev_count      <= '0;
                r_ev_ovf        <= 1'b0;
                r_close_pending <= i_step_close;
            end else begin
                if (r_state == RUN && i_step_close) r_close_pending <= 1'b1;
                if (w_grant) begin
                    if (&r_ev_count) r_ev_ovf   <= 1'b1;
                    else             r_ev_count <= r_ev_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_ack      = r_ack;
    assign o_ev_valid = r_ev_valid;
    assign o_ev_addr  = r_ev_addr;
    assign o_ev_count = r_ev_count;
    assign o_ev_ovf   = r_ev_ovf;
    assign o_timer_en = (r_state == TICK);
    assign o_busy     = (r_state != IDLE);

endmodule
